nand_bmask_pipe: RTL and testbench

//  Multi-channel, parametrised NAND/AND gate with per-input inversion mask. Generalises the

---
 rtl/nand_pkg.sv | 18 +
 rtl/nand_pipe_stage.sv | 45 ++++
 rtl/nand_bmask_pipe.sv | 104 ++++++++++
 tb/tb_nand_bmask_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nand_pkg.sv
// rtl/nand_pkg.sv - shared constants and helpers for the masked NAND/AND pipeline
package nand_pkg;

    localparam logic [4:0] DEFAULT_INV_MASK = 5'b00011;
    localparam logic       MODE_NAND        = 1'b0;
    localparam logic       MODE_AND         = 1'b1;

    // Ceiling log2, minimum result 0; used for elaboration-time widths only.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nand_pipe_stage.sv
// rtl/nand_pipe_stage.sv - one elastic valid/ready register slice
module nand_pipe_stage #(
    parameter int CHANNELS = 2
) (
    input  logic                C,
    input  logic                CLR,
    input  logic                in_valid,
    input  logic [CHANNELS-1:0] in_data,
    input  logic                out_ready,
    output logic                in_ready,
    output logic                out_valid,
    output logic [CHANNELS-1:0] out_data
);

    logic                valid_d, valid_q;
    logic [CHANNELS-1:0] data_d, data_q;

    // An empty slice always accepts, so bubbles collapse under a stalled consumer.
    assign in_ready = !valid_q || out_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/nand_bmask_pipe.sv
// rtl/nand_bmask_pipe.sv - multi-channel masked NAND/AND with elastic register pipeline
module nand_bmask_pipe
    import nand_pkg::*;
#(
    parameter int               WIDTH    = 5,
    parameter int               CHANNELS = 2,
    parameter logic [WIDTH-1:0] INV_MASK = WIDTH'(DEFAULT_INV_MASK),
    parameter int               STAGES   = 2
) (
    input  logic                         C,
    input  logic                         CLR,
    input  logic [CHANNELS*WIDTH-1:0]    I,
    input  logic                         MODE,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    output logic [CHANNELS-1:0]          O,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [clog2(STAGES+1)-1:0]   OCCUPANCY
);

    localparam int OCC_W = clog2(STAGES + 1);

    logic [CHANNELS-1:0] func_data;

    always_comb begin
        func_data = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (MODE == MODE_NAND) begin
                func_data[c] = ~(&(I[c*WIDTH +: WIDTH] ^ INV_MASK));
            end else begin
                func_data[c] = &(I[c*WIDTH +: WIDTH] ^ INV_MASK);
            end
        end
    end

    // Each slice keeps its own nets so the ready chain is not one circular vector.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic                up_valid;
        logic [CHANNELS-1:0] up_data;
        logic                dn_ready;
        logic                st_in_ready;
        logic                st_valid;
        logic [CHANNELS-1:0] st_data;

        if (k == 0) begin : g_head
            assign up_valid = IN_VALID;
            assign up_data  = func_data;
        end else begin : g_body
            assign up_valid = g_stage[k-1].st_valid;
            assign up_data  = g_stage[k-1].st_data;
        end

        if (k == STAGES - 1) begin : g_tail
            assign dn_ready = OUT_READY;
        end else begin : g_link
            assign dn_ready = g_stage[k+1].st_in_ready;
        end

        nand_pipe_stage #(
            .CHANNELS (CHANNELS)
        ) u_stage (
            .C         (C),
            .CLR       (CLR),
            .in_valid  (up_valid),
            .in_data   (up_data),
            .out_ready (dn_ready),
            .in_ready  (st_in_ready),
            .out_valid (st_valid),
            .out_data  (st_data)
        );
    end

    assign IN_READY  = g_stage[0].st_in_ready;
    assign OUT_VALID = g_stage[STAGES-1].st_valid;
    assign O         = g_stage[STAGES-1].st_data;

    // Internal slice-to-slice moves never change the count; only the two ends do.
    logic             in_xfer, out_xfer;
    logic [OCC_W-1:0] occ_d, occ_q;

    assign in_xfer  = IN_VALID && IN_READY;
    assign out_xfer = OUT_VALID && OUT_READY;

    always_comb begin
        occ_d = occ_q;
        if (in_xfer && !out_xfer) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_xfer && out_xfer) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign OCCUPANCY = occ_q;

endmodule

// File: tb/tb_nand_bmask_pipe.sv
// tb/tb_nand_bmask_pipe.sv - directed vector and scoreboard bench for nand_bmask_pipe
module tb_nand_bmask_pipe;

    localparam logic [15:0] MASK2 = 16'hA5C3;

    logic        clk;
    logic        clr;
    logic [9:0]  i1;
    logic        mode1, v1, r1;
    logic        ir1, ov1;
    logic [1:0]  o1;
    logic [1:0]  occ1;

    logic [127:0] i2;
    logic         mode2, v2, r2;
    logic         ir2, ov2;
    logic [7:0]   o2;
    logic [2:0]   occ2;

    int n_checks;
    int n_fail;

    typedef struct {
        logic [9:0] i;
        logic       mode;
        logic [1:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [7:0]  sb [$];

    nand_bmask_pipe dut (
        .C         (clk),
        .CLR       (clr),
        .I         (i1),
        .MODE      (mode1),
        .IN_VALID  (v1),
        .IN_READY  (ir1),
        .O         (o1),
        .OUT_VALID (ov1),
        .OUT_READY (r1),
        .OCCUPANCY (occ1)
    );

    nand_bmask_pipe #(
        .WIDTH    (16),
        .CHANNELS (8),
        .INV_MASK (MASK2),
        .STAGES   (4)
    ) dut2 (
        .C         (clk),
        .CLR       (clr),
        .I         (i2),
        .MODE      (mode2),
        .IN_VALID  (v2),
        .IN_READY  (ir2),
        .O         (o2),
        .OUT_VALID (ov2),
        .OUT_READY (r2),
        .OCCUPANCY (occ2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model2(input logic [127:0] din, input logic md);
        logic [7:0] res;
        for (int c = 0; c < 8; c++) begin
            res[c] = &(din[c*16 +: 16] ^ MASK2);
            if (!md) res[c] = ~res[c];
        end
        return res;
    endfunction

    function automatic logic [127:0] rand_in2();
        logic [127:0] d;
        logic [15:0]  ch;
        for (int c = 0; c < 8; c++) begin
            case ($urandom_range(0, 2))
                0:       ch = ~MASK2;
                1:       ch = ~MASK2 ^ (16'h1 << $urandom_range(0, 15));
                default: ch = 16'($urandom);
            endcase
            d[c*16 +: 16] = ch;
        end
        return d;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{{5'b11111, 5'b11100}, 1'b0, 2'b10};
        vecs[1] = '{{5'b11111, 5'b11100}, 1'b1, 2'b01};
        vecs[2] = '{{5'b11100, 5'b11100}, 1'b1, 2'b11};
        vecs[3] = '{{5'b11100, 5'b11100}, 1'b0, 2'b00};
        vecs[4] = '{{5'b00000, 5'b00000}, 1'b0, 2'b11};
        vecs[5] = '{{5'b00000, 5'b00000}, 1'b1, 2'b00};
        vecs[6] = '{{5'b11100, 5'b00000}, 1'b1, 2'b10};
        vecs[7] = '{{5'b11101, 5'b11100}, 1'b0, 2'b10};

        clr = 1'b0;
        i1 = '0; mode1 = 1'b0; v1 = 1'b0; r1 = 1'b1;
        i2 = '0; mode2 = 1'b0; v2 = 1'b0; r2 = 1'b1;
        #1 clr = 1'b1;
        #11;
        check("reset_out_valid", 32'(ov1), 32'd0);
        check("reset_o", 32'(o1), 32'd0);
        check("reset_occ", 32'(occ1), 32'd0);
        check("reset_in_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        clr = 1'b0;
        next_cycle();

        // Back-to-back stream of the whole table: result j appears two cycles after its transfer.
        for (int j = 0; j < 11; j++) begin
            if (j < 8) begin
                i1 = vecs[j].i; mode1 = vecs[j].mode; v1 = 1'b1;
            end else begin
                v1 = 1'b0;
            end
            @(negedge clk);
            if (j < 8) check($sformatf("stream_in_ready_%0d", j), 32'(ir1), 32'd1);
            if (j >= 2 && j < 10) begin
                check($sformatf("stream_valid_%0d", j - 2), 32'(ov1), 32'd1);
                check($sformatf("stream_o_%0d", j - 2), 32'(o1), 32'(vecs[j-2].exp));
            end else begin
                check($sformatf("stream_idle_%0d", j), 32'(ov1), 32'd0);
            end
            next_cycle();
        end

        // Backpressure: three pushes against a stalled consumer.
        r1 = 1'b0;
        i1 = vecs[0].i; mode1 = vecs[0].mode; v1 = 1'b1;
        @(negedge clk);
        check("bp_ready_a", 32'(ir1), 32'd1);
        next_cycle();
        i1 = vecs[1].i; mode1 = vecs[1].mode;
        @(negedge clk);
        check("bp_ready_b", 32'(ir1), 32'd1);
        next_cycle();
        i1 = vecs[2].i; mode1 = vecs[2].mode;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("bp_full_ready", 32'(ir1), 32'd0);
            check("bp_full_occ", 32'(occ1), 32'd2);
            check("bp_stable_valid", 32'(ov1), 32'd1);
            check("bp_stable_o", 32'(o1), 32'(vecs[0].exp));
            next_cycle();
        end
        r1 = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(ir1), 32'd1);
        check("bp_release_o", 32'(o1), 32'(vecs[0].exp));
        next_cycle();
        v1 = 1'b0;
        @(negedge clk);
        check("bp_second_o", 32'(o1), 32'(vecs[1].exp));
        check("bp_second_occ", 32'(occ1), 32'd2);
        next_cycle();
        @(negedge clk);
        check("bp_third_o", 32'(o1), 32'(vecs[2].exp));
        check("bp_third_valid", 32'(ov1), 32'd1);
        check("bp_third_occ", 32'(occ1), 32'd1);
        next_cycle();
        @(negedge clk);
        check("bp_drained_valid", 32'(ov1), 32'd0);
        check("bp_drained_occ", 32'(occ1), 32'd0);
        next_cycle();

        // Bubble collapse: a lone result walks to the last slice while output is stalled.
        r1 = 1'b0;
        i1 = vecs[7].i; mode1 = vecs[7].mode; v1 = 1'b1;
        next_cycle();
        v1 = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        check("bubble_valid", 32'(ov1), 32'd1);
        check("bubble_o", 32'(o1), 32'(vecs[7].exp));
        check("bubble_occ", 32'(occ1), 32'd1);
        check("bubble_in_ready", 32'(ir1), 32'd1);
        next_cycle();
        r1 = 1'b1;
        next_cycle();
        @(negedge clk);
        check("bubble_drained", 32'(ov1), 32'd0);
        next_cycle();

        // Asynchronous reset with the pipeline full.
        r1 = 1'b0;
        i1 = vecs[5].i; mode1 = vecs[5].mode; v1 = 1'b1;
        next_cycle();
        i1 = vecs[6].i; mode1 = vecs[6].mode;
        next_cycle();
        v1 = 1'b0;
        @(negedge clk);
        check("midrst_pre_occ", 32'(occ1), 32'd2);
        #2 clr = 1'b1;
        #1;
        check("midrst_out_valid", 32'(ov1), 32'd0);
        check("midrst_o", 32'(o1), 32'd0);
        check("midrst_occ", 32'(occ1), 32'd0);
        check("midrst_in_ready", 32'(ir1), 32'd1);
        @(negedge clk);
        clr = 1'b0;
        r1 = 1'b1;
        i1 = vecs[1].i; mode1 = vecs[1].mode; v1 = 1'b1;
        next_cycle();
        v1 = 1'b0;
        @(negedge clk);
        check("postrst_lat1", 32'(ov1), 32'd0);
        next_cycle();
        @(negedge clk);
        check("postrst_valid", 32'(ov1), 32'd1);
        check("postrst_o", 32'(o1), 32'(vecs[1].exp));
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("postrst_no_stale", 32'(ov1), 32'd0);
            next_cycle();
        end

        // Wide configuration under random traffic against a queue scoreboard.
        for (int cyc = 0; cyc < 600; cyc++) begin
            i2    = rand_in2();
            mode2 = 1'($urandom_range(0, 1));
            v2    = ($urandom_range(0, 3) != 0);
            r2    = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            check("sweep_occ", 32'(occ2), 32'(sb.size()));
            if (ov2 && r2) begin
                if (sb.size() == 0) begin
                    check("sweep_unexpected_out", 32'd1, 32'd0);
                end else begin
                    check("sweep_o", 32'(o2), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            if (v2 && ir2) sb.push_back(model2(i2, mode2));
            next_cycle();
        end
        v2 = 1'b0;
        r2 = 1'b1;
        for (int cyc = 0; cyc < 20 && sb.size() > 0; cyc++) begin
            @(negedge clk);
            if (ov2) begin
                check("drain_o", 32'(o2), 32'(sb[0]));
                void'(sb.pop_front());
            end
            next_cycle();
        end
        @(negedge clk);
        check("drain_empty", 32'(sb.size()), 32'd0);
        check("drain_valid", 32'(ov2), 32'd0);
        check("drain_occ", 32'(occ2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
